// File: rtl/column_subband_splitter.sv
`default_nettype none
// ============================================================================
//  Module   : column_subband_splitter
//  Purpose  : Splits the {vertical high, vertical low} coefficient-pair stream
//             from the column 9/7 DWT stage into the four 2-D subbands
//             LL, HL, LH and HH, using horizontal column parity.
//             The even-column beat of each column pair is parked in an
//             internal pair register. All four subband registers are loaded
//             together when the matching odd-column beat arrives, so LL/LH
//             can carry the end-of-line flag of that odd beat.
//  Ports    : clk_i, rst_i          clock, synchronous active-high reset
//             s_valid_i/s_ready_o   input handshake
//             s_sof_i, s_eol_i      first beat of frame, last beat of line
//             s_data_i              {vertical high, vertical low}
//             m_xx_valid_o/ready_i  per-subband output handshake (xx = ll,
//             m_xx_sof_o/eol_o      hl, lh, hh), each with its own one-deep
//             m_xx_data_o           output register
//             err_o                 sticky protocol error
//  Revision : 1.0  initial release
// ============================================================================
module column_subband_splitter #(
   parameter int DataWidth       = 16,
   parameter int MaximumSideSize = 512
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   output logic                   s_ready_o,
   input  logic                   s_valid_i,
   input  logic                   s_sof_i,
   input  logic                   s_eol_i,
   input  logic [2*DataWidth-1:0] s_data_i,
   input  logic                   m_ll_ready_i,
   output logic                   m_ll_valid_o,
   output logic                   m_ll_sof_o,
   output logic                   m_ll_eol_o,
   output logic [DataWidth-1:0]   m_ll_data_o,
   input  logic                   m_hl_ready_i,
   output logic                   m_hl_valid_o,
   output logic                   m_hl_sof_o,
   output logic                   m_hl_eol_o,
   output logic [DataWidth-1:0]   m_hl_data_o,
   input  logic                   m_lh_ready_i,
   output logic                   m_lh_valid_o,
   output logic                   m_lh_sof_o,
   output logic                   m_lh_eol_o,
   output logic [DataWidth-1:0]   m_lh_data_o,
   input  logic                   m_hh_ready_i,
   output logic                   m_hh_valid_o,
   output logic                   m_hh_sof_o,
   output logic                   m_hh_eol_o,
   output logic [DataWidth-1:0]   m_hh_data_o,
   output logic                   err_o
);

   localparam int                 c_col_w    = $clog2(MaximumSideSize);
   localparam logic [c_col_w-1:0] c_col_last = c_col_w'(MaximumSideSize - 1);
   localparam logic [c_col_w-1:0] c_col_one  = c_col_w'(1);

   // Subband register index: 0 = LL, 1 = HL, 2 = LH, 3 = HH
   logic [3:0]           r_valid;
   logic [3:0]           r_sof;
   logic [3:0]           r_eol;
   logic [DataWidth-1:0] r_data [4];

   // Parked even-column beat and frame bookkeeping
   logic [DataWidth-1:0] r_hold_hi;
   logic [DataWidth-1:0] r_hold_lo;
   logic                 r_hold_sof;
   logic                 r_pend_sof;
   logic [c_col_w-1:0]   r_col;
   logic                 r_err;

   logic [3:0]           w_ready;
   logic [3:0]           w_free;
   logic                 w_even;
   logic                 w_accept;
   logic                 w_even_eol;
   logic                 w_odd_acc;
   logic                 w_hold_wr;
   logic [3:0]           w_load;
   logic [3:0]           w_ld_sof;
   logic [3:0]           w_ld_eol;
   logic [DataWidth-1:0] w_ld_data [4];
   logic [DataWidth-1:0] w_hi;
   logic [DataWidth-1:0] w_lo;
   logic                 w_err_set;

   assign w_hi    = s_data_i[2*DataWidth-1:DataWidth];
   assign w_lo    = s_data_i[DataWidth-1:0];
   assign w_ready = {m_hh_ready_i, m_lh_ready_i, m_hl_ready_i, m_ll_ready_i};
   assign w_free  = ~r_valid | w_ready;

   // A start-of-frame beat always opens a new column pair, even when it
   // arrives on an odd column; the stale parked beat is then overwritten.
   assign w_even  = s_sof_i | ~r_col[0];

   // Even beats only reach LL/LH directly on an odd-width line, but the
   // LL/LH free condition is required regardless so that case never stalls
   // mid-beat.
   assign s_ready_o = w_even ? (w_free[0] & w_free[2]) : (&w_free);
   assign w_accept  = s_valid_i & s_ready_o;

   assign w_even_eol = w_accept &  w_even & s_eol_i;
   assign w_odd_acc  = w_accept & ~w_even;
   assign w_hold_wr  = w_accept &  w_even & ~s_eol_i;
   assign w_load     = {w_odd_acc, w_odd_acc | w_even_eol,
                        w_odd_acc, w_odd_acc | w_even_eol};

   always_comb begin
      w_ld_data[0] = w_even ? w_lo : r_hold_lo;
      w_ld_data[1] = w_lo;
      w_ld_data[2] = w_even ? w_hi : r_hold_hi;
      w_ld_data[3] = w_hi;
      w_ld_sof     = '0;
      w_ld_sof[0]  = w_even ? s_sof_i : r_hold_sof;
      w_ld_sof[2]  = w_ld_sof[0];
      w_ld_sof[1]  = r_pend_sof;
      w_ld_sof[3]  = r_pend_sof;
      w_ld_eol     = {4{s_eol_i}};
   end

   assign w_err_set = w_accept & ((s_sof_i & r_col[0]) |
                                  (w_even & s_eol_i)   |
                                  (~s_eol_i & ~s_sof_i & (r_col == c_col_last)));

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_valid    <= '0;
         r_sof      <= '0;
         r_eol      <= '0;
         r_hold_sof <= 1'b0;
         r_pend_sof <= 1'b0;
         r_col      <= '0;
         r_err      <= 1'b0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (w_load[i]) begin
               r_valid[i] <= 1'b1;
               r_sof[i]   <= w_ld_sof[i];
               r_eol[i]   <= w_ld_eol[i];
            end else if (w_ready[i]) begin
               r_valid[i] <= 1'b0;
            end
         end

         if (w_hold_wr) begin
            r_hold_sof <= s_sof_i;
         end

         // The pending flag carries frame start from the even beat to the
         // HL/HH registers of the next odd beat.
         if (w_accept) begin
            if (w_even) begin
               if (s_sof_i) begin
                  r_pend_sof <= 1'b1;
               end
            end else begin
               r_pend_sof <= 1'b0;
            end
         end

         if (w_accept) begin
            if (s_eol_i) begin
               r_col <= '0;
            end else if (s_sof_i) begin
               r_col <= c_col_one;
            end else if (r_col == c_col_last) begin
               r_col <= '0;
            end else begin
               r_col <= r_col + c_col_one;
            end
         end

         if (w_err_set) begin
            r_err <= 1'b1;
         end
      end
   end

   // Data paths carry no reset.
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < 4; i++) begin
         if (w_load[i]) begin
            r_data[i] <= w_ld_data[i];
         end
      end
      if (w_hold_wr) begin
         r_hold_hi <= w_hi;
         r_hold_lo <= w_lo;
      end
   end

   assign m_ll_valid_o = r_valid[0];
   assign m_ll_sof_o   = r_sof[0];
   assign m_ll_eol_o   = r_eol[0];
   assign m_ll_data_o  = r_data[0];
   assign m_hl_valid_o = r_valid[1];
   assign m_hl_sof_o   = r_sof[1];
   assign m_hl_eol_o   = r_eol[1];
   assign m_hl_data_o  = r_data[1];
   assign m_lh_valid_o = r_valid[2];
   assign m_lh_sof_o   = r_sof[2];
   assign m_lh_eol_o   = r_eol[2];
   assign m_lh_data_o  = r_data[2];
   assign m_hh_valid_o = r_valid[3];
   assign m_hh_sof_o   = r_sof[3];
   assign m_hh_eol_o   = r_eol[3];
   assign m_hh_data_o  = r_data[3];
   assign err_o        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_column_subband_splitter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_column_subband_splitter
//  Purpose  : Scoreboard bench for column_subband_splitter. Stimulus pushes
//             expected {sof, eol, data} entries per subband; a monitor pops
//             and compares on every output transfer.
//  Revision : 1.0  initial release
// ============================================================================
module tb_column_subband_splitter;
   localparam int DW = 16;
   typedef logic [DW+1:0] ent_t;   // {sof, eol, data}

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic          s_ready, s_valid, s_sof, s_eol;
   logic [2*DW-1:0] s_data;
   logic [3:0]    rdy;
   logic [3:0]    mv, ms, me;
   logic [DW-1:0] md [4];
   logic          err;

   column_subband_splitter #(.DataWidth(DW), .MaximumSideSize(512)) dut (
      .clk_i(clk), .rst_i(rst),
      .s_ready_o(s_ready), .s_valid_i(s_valid), .s_sof_i(s_sof),
      .s_eol_i(s_eol), .s_data_i(s_data),
      .m_ll_ready_i(rdy[0]), .m_ll_valid_o(mv[0]), .m_ll_sof_o(ms[0]),
      .m_ll_eol_o(me[0]), .m_ll_data_o(md[0]),
      .m_hl_ready_i(rdy[1]), .m_hl_valid_o(mv[1]), .m_hl_sof_o(ms[1]),
      .m_hl_eol_o(me[1]), .m_hl_data_o(md[1]),
      .m_lh_ready_i(rdy[2]), .m_lh_valid_o(mv[2]), .m_lh_sof_o(ms[2]),
      .m_lh_eol_o(me[2]), .m_lh_data_o(md[2]),
      .m_hh_ready_i(rdy[3]), .m_hh_valid_o(mv[3]), .m_hh_sof_o(ms[3]),
      .m_hh_eol_o(me[3]), .m_hh_data_o(md[3]),
      .err_o(err)
   );

   ent_t sbq [4][$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   pops [4];
   bit   use_model;
   bit   rnd_en;

   // Reference state for the generic routing model
   logic [DW-1:0] mh_h, mh_l;
   logic          mh_sof, m_pend;
   int            m_col;

   function automatic string nm(input int i);
      case (i)
         0: return "LL";
         1: return "HL";
         2: return "LH";
         default: return "HH";
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Monitor: transfers seen at the negedge complete on the next posedge.
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 4; i++) begin
            if (mv[i] && rdy[i]) begin
               ent_t got;
               ent_t exp;
               got = {ms[i], me[i], md[i]};
               n_tests++;
               if (sbq[i].size() == 0) begin
                  n_fail++;
                  $display("FAIL %s_unexpected: got %h expected none", nm(i), got);
               end else begin
                  exp = sbq[i].pop_front();
                  pops[i]++;
                  if (got !== exp) begin
                     n_fail++;
                     $display("FAIL %s_beat: got sof/eol/data %h expected %h", nm(i), got, exp);
                  end
               end
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_en) begin
            for (int i = 0; i < 4; i++) rdy[i] = ($urandom_range(0, 3) != 0);
         end
      end
   end

   task automatic push(input int i, input logic s, input logic e, input logic [DW-1:0] d);
      sbq[i].push_back({s, e, d});
   endtask

   task automatic model(input logic [DW-1:0] h, input logic [DW-1:0] l,
                        input logic sof, input logic eol);
      bit even;
      even = sof || (m_col % 2 == 0);
      if (even) begin
         if (eol) begin
            push(0, sof, 1'b1, l);
            push(2, sof, 1'b1, h);
         end else begin
            mh_h = h; mh_l = l; mh_sof = sof;
         end
         if (sof) m_pend = 1'b1;
      end else begin
         push(0, mh_sof, eol, mh_l);
         push(2, mh_sof, eol, mh_h);
         push(1, m_pend, eol, l);
         push(3, m_pend, eol, h);
         m_pend = 1'b0;
      end
      m_col = eol ? 0 : (sof ? 1 : m_col + 1);
   endtask

   // Called at posedge+1; returns at posedge+1 after the beat is accepted.
   task automatic send(input logic [DW-1:0] h, input logic [DW-1:0] l,
                       input logic sof, input logic eol);
      int t;
      t = 0;
      s_valid = 1'b1; s_data = {h, l}; s_sof = sof; s_eol = eol;
      if (use_model) model(h, l, sof, eol);
      forever begin
         @(negedge clk);
         if (s_ready) break;
         t++;
         if (t >= 200) begin
            n_tests++; n_fail++;
            $display("FAIL send_timeout: got s_ready_o 0 expected 1 within 200 cycles");
            break;
         end
      end
      @(posedge clk);
      #1;
      s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
   endtask

   task automatic clear_sb();
      for (int i = 0; i < 4; i++) begin
         sbq[i].delete();
         pops[i] = 0;
      end
      m_col = 0; m_pend = 1'b0; mh_sof = 1'b0;
   endtask

   task automatic reset_dut();
      rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_eol = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      clear_sb();
   endtask

   task automatic drain();
      int t;
      t = 0;
      while ((sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size()) != 0 && t < 2000) begin
         @(posedge clk);
         t++;
      end
      #1;
      check("drain_left", sbq[0].size() + sbq[1].size() + sbq[2].size() + sbq[3].size(), 0);
   endtask

   initial begin
      rdy = 4'hF; rnd_en = 0; use_model = 0;
      s_valid = 0; s_data = '0; s_sof = 0; s_eol = 0; rst = 1;
      clear_sb();

      // Reset state
      reset_dut();
      check("reset_valid", {28'd0, mv}, 0);
      check("reset_err", {31'd0, err}, 0);
      check("reset_ready", {31'd0, s_ready}, 1);

      // 4x2 frame, hand-computed expectations
      use_model = 0;
      for (int ln = 0; ln < 2; ln++) begin
         logic f;
         f = (ln == 0);
         push(0, f, 0, 16'd2); push(2, f, 0, 16'd1); push(1, f, 0, 16'd4); push(3, f, 0, 16'd3);
         push(0, 0, 1, 16'd6); push(2, 0, 1, 16'd5); push(1, 0, 1, 16'd8); push(3, 0, 1, 16'd7);
         send(1, 2, f, 0); send(3, 4, 0, 0); send(5, 6, 0, 0); send(7, 8, 0, 1);
      end
      drain();
      check("frame_err", {31'd0, err}, 0);
      check("frame_count_ll", pops[0], 4);

      // HH stalled while the second pair waits
      reset_dut();
      use_model = 1;
      rdy = 4'hF; rdy[3] = 0;
      send(1, 2, 1, 0); send(3, 4, 0, 0); send(5, 6, 0, 0);
      fork
         send(7, 8, 0, 1);
         begin
            repeat (5) begin
               @(negedge clk);
               check("stall_ready", {31'd0, s_ready}, 0);
               check("stall_hh_valid", {31'd0, mv[3]}, 1);
               check("stall_hh_data", {16'd0, md[3]}, 3);
            end
            @(posedge clk);
            #1 rdy[3] = 1;
         end
      join
      send(1, 2, 0, 0); send(3, 4, 0, 0); send(5, 6, 0, 0); send(7, 8, 0, 1);
      drain();
      check("stall_err", {31'd0, err}, 0);
      check("stall_count_hh", pops[3], 4);

      // 16x4 frame with random readies
      reset_dut();
      use_model = 1; rnd_en = 1;
      for (int ln = 0; ln < 4; ln++) begin
         for (int c = 0; c < 16; c++) begin
            send(16'(16'h1000 + ln * 64 + c * 2), 16'(16'h2001 + ln * 64 + c * 2),
                 (ln == 0 && c == 0), (c == 15));
         end
      end
      drain();
      rnd_en = 0; rdy = 4'hF;
      for (int i = 0; i < 4; i++) check({"rand_count_", nm(i)}, pops[i], 32);
      check("rand_err", {31'd0, err}, 0);

      // Odd line width (3 beats)
      reset_dut();
      use_model = 0;
      push(0, 1, 0, 16'd2); push(2, 1, 0, 16'd1); push(1, 1, 0, 16'd4); push(3, 1, 0, 16'd3);
      push(0, 0, 1, 16'd6); push(2, 0, 1, 16'd5);
      push(0, 0, 1, 16'd10); push(2, 0, 1, 16'd9); push(1, 0, 1, 16'd12); push(3, 0, 1, 16'd11);
      send(1, 2, 1, 0); send(3, 4, 0, 0);
      check("w3_err_before", {31'd0, err}, 0);
      send(5, 6, 0, 1);
      check("w3_err_after", {31'd0, err}, 1);
      send(9, 10, 0, 0); send(11, 12, 0, 1);
      drain();

      // Reset while LL holds a valid beat
      reset_dut();
      use_model = 0;
      rdy = 4'h0;
      send(1, 2, 1, 0); send(3, 4, 0, 0);
      @(negedge clk);
      check("rst_pre_ll_valid", {31'd0, mv[0]}, 1);
      @(posedge clk);
      #1 rst = 1;
      @(posedge clk);
      #1;
      check("rst_mid_valid", {28'd0, mv}, 0);
      check("rst_mid_err", {31'd0, err}, 0);
      rst = 0;
      clear_sb();
      rdy = 4'hF;
      use_model = 1;
      send(21, 22, 1, 0); send(23, 24, 0, 0); send(25, 26, 0, 0); send(27, 28, 0, 1);
      drain();
      check("rst_post_count_hl", pops[1], 2);

      // sof on the second beat of a line
      reset_dut();
      use_model = 0;
      push(0, 1, 0, 16'd4); push(2, 1, 0, 16'd3); push(1, 1, 0, 16'd6); push(3, 1, 0, 16'd5);
      push(0, 0, 1, 16'd8); push(2, 0, 1, 16'd7); push(1, 0, 1, 16'd10); push(3, 0, 1, 16'd9);
      send(1, 2, 0, 0);
      check("sof2_err_before", {31'd0, err}, 0);
      send(3, 4, 1, 0);
      check("sof2_err_after", {31'd0, err}, 1);
      send(5, 6, 0, 0); send(7, 8, 0, 0); send(9, 10, 0, 1);
      drain();
      check("sof2_err_sticky", {31'd0, err}, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end
endmodule
`default_nettype wire
